// File: rtl/elevator_run_indicator.sv
// Elevator car motion controller with a direction-showing LED chaser.
// One request at a time; the car steps one floor per LED_W animation ticks.
module elevator_run_indicator #(
  parameter int FLOORS   = 4,
  parameter int LED_W    = 5,
  parameter int TICK_DIV = 47000000,
  localparam int FW = (FLOORS > 2) ? $clog2(FLOORS) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_stop,
  input  logic             req_valid,
  input  logic [FW-1:0]    req_floor,
  output logic             req_ready,
  output logic [LED_W-1:0] led,
  output logic [FW-1:0]    cur_floor,
  output logic             moving,
  output logic             dir_up,
  output logic             arrive
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int PW = $clog2(LED_W);

  localparam logic [CW-1:0] TICK_LAST = CW'(TICK_DIV - 1);
  localparam logic [PW-1:0] PH_LAST   = PW'(LED_W - 1);
  localparam logic [FW:0]   FLOORS_W  = (FW + 1)'(FLOORS);

  localparam logic [LED_W-1:0] LED_UP0 = {{(LED_W-1){1'b0}}, 1'b1};
  localparam logic [LED_W-1:0] LED_DN0 = {1'b1, {(LED_W-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_UP,
    S_DOWN
  } state_e;

  state_e           state_q, state_d;
  logic [FW-1:0]    tgt_q, tgt_d;
  logic [FW-1:0]    cur_q, cur_d;
  logic [LED_W-1:0] led_q, led_d;
  logic [PW-1:0]    ph_q, ph_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             arrive_q, arrive_d;
  logic             moving_q, moving_d;
  logic             dir_up_q, dir_up_d;
  logic             ready_q, ready_d;

  logic             tick;
  logic             req_ok;
  logic             going_up;
  logic [FW-1:0]    nxt_floor;

  always_comb begin
    state_d   = state_q;
    tgt_d     = tgt_q;
    cur_d     = cur_q;
    led_d     = led_q;
    ph_d      = ph_q;
    cnt_d     = cnt_q;
    arrive_d  = 1'b0;
    tick      = (cnt_q == TICK_LAST);
    req_ok    = req_valid && ({1'b0, req_floor} < FLOORS_W);
    going_up  = (state_q == S_UP);
    nxt_floor = going_up ? cur_q + 1'b1 : cur_q - 1'b1;

    unique case (state_q)
      S_IDLE: begin
        if (req_ok) begin
          if (req_floor == cur_q) begin
            arrive_d = 1'b1;
          end else begin
            tgt_d = req_floor;
            ph_d  = '0;
            cnt_d = '0;
            if (req_floor > cur_q) begin
              state_d = S_UP;
              led_d   = LED_UP0;
            end else begin
              state_d = S_DOWN;
              led_d   = LED_DN0;
            end
          end
        end
      end
      S_UP, S_DOWN: begin
        // Everything freezes while the run enable is low.
        if (start_stop) begin
          cnt_d = tick ? '0 : cnt_q + 1'b1;
          if (tick) begin
            if (ph_q != PH_LAST) begin
              ph_d  = ph_q + 1'b1;
              led_d = going_up ? led_q << 1 : led_q >> 1;
            end else begin
              cur_d = nxt_floor;
              ph_d  = '0;
              if (nxt_floor == tgt_q) begin
                state_d  = S_IDLE;
                led_d    = '0;
                arrive_d = 1'b1;
              end else begin
                led_d = going_up ? LED_UP0 : LED_DN0;
              end
            end
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        led_d   = '0;
      end
    endcase

    moving_d = (state_d != S_IDLE);
    dir_up_d = (state_d == S_UP);
    ready_d  = (state_d == S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      tgt_q    <= '0;
      cur_q    <= '0;
      led_q    <= '0;
      ph_q     <= '0;
      cnt_q    <= '0;
      arrive_q <= 1'b0;
      moving_q <= 1'b0;
      dir_up_q <= 1'b0;
      ready_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      tgt_q    <= tgt_d;
      cur_q    <= cur_d;
      led_q    <= led_d;
      ph_q     <= ph_d;
      cnt_q    <= cnt_d;
      arrive_q <= arrive_d;
      moving_q <= moving_d;
      dir_up_q <= dir_up_d;
      ready_q  <= ready_d;
    end
  end

  assign req_ready = ready_q;
  assign led       = led_q;
  assign cur_floor = cur_q;
  assign moving    = moving_q;
  assign dir_up    = dir_up_q;
  assign arrive    = arrive_q;

endmodule

// File: tb/tb_elevator_run_indicator.sv
// Directed bench for elevator_run_indicator (4 floors, 5 LEDs, tick/4),
// plus a 3-floor instance for out-of-range request handling.
module tb_elevator_run_indicator;

  logic       clk = 1'b0;
  logic       reset;
  logic       start_stop;
  logic       req_valid;
  logic [1:0] req_floor;
  logic       req_ready;
  logic [4:0] led;
  logic [1:0] cur_floor;
  logic       moving;
  logic       dir_up;
  logic       arrive;

  logic       req_valid3;
  logic [1:0] req_floor3;
  logic       req_ready3;
  logic [4:0] led3;
  logic [1:0] cur_floor3;
  logic       moving3;
  logic       dir_up3;
  logic       arrive3;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  elevator_run_indicator #(
    .FLOORS(4), .LED_W(5), .TICK_DIV(4)
  ) u_dut (
    .clk(clk), .reset(reset), .start_stop(start_stop),
    .req_valid(req_valid), .req_floor(req_floor),
    .req_ready(req_ready), .led(led), .cur_floor(cur_floor),
    .moving(moving), .dir_up(dir_up), .arrive(arrive)
  );

  elevator_run_indicator #(
    .FLOORS(3), .LED_W(5), .TICK_DIV(4)
  ) u_dut3 (
    .clk(clk), .reset(reset), .start_stop(start_stop),
    .req_valid(req_valid3), .req_floor(req_floor3),
    .req_ready(req_ready3), .led(led3), .cur_floor(cur_floor3),
    .moving(moving3), .dir_up(dir_up3), .arrive(arrive3)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) @(posedge clk);
    #1;
  endtask

  task automatic request(input logic [1:0] f);
    req_valid = 1'b1;
    req_floor = f;
    step(1);
    req_valid = 1'b0;
  endtask

  initial begin
    reset      = 1'b1;
    start_stop = 1'b1;
    req_valid  = 1'b1;
    req_floor  = 2'd3;
    req_valid3 = 1'b0;
    req_floor3 = 2'd0;
    step(2);
    chk("rst_led", led, 5'b00000);
    chk("rst_floor", cur_floor, 0);
    chk("rst_ready", req_ready, 1);
    chk("rst_moving", moving, 0);
    chk("rst_arrive", arrive, 0);
    chk("rst_dir", dir_up, 0);
    req_valid = 1'b0;
    reset     = 1'b0;
    step(1);
    chk("rst_noacc", moving, 0);

    // 3-floor instance: floor 3 is a legal 2-bit code but out of range.
    req_valid3 = 1'b1;
    req_floor3 = 2'd3;
    step(1);
    chk("f3_ign_mov", moving3, 0);
    chk("f3_ign_rdy", req_ready3, 1);
    chk("f3_ign_arr", arrive3, 0);
    req_floor3 = 2'd2;
    step(1);
    req_valid3 = 1'b0;
    chk("f3_ok_mov", moving3, 1);
    chk("f3_ok_led", led3, 5'b00001);

    // 0 -> 2, running
    request(2'd2);
    chk("up_led0", led, 5'b00001);
    chk("up_dir", dir_up, 1);
    chk("up_mov", moving, 1);
    chk("up_rdy", req_ready, 0);
    step(4);
    chk("up_led4", led, 5'b00010);
    step(16);
    chk("up_fl20", cur_floor, 1);
    chk("up_led20", led, 5'b00001);
    step(19);
    chk("up_arr39", arrive, 0);
    chk("up_led39", led, 5'b10000);
    step(1);
    chk("up_arr40", arrive, 1);
    chk("up_fl40", cur_floor, 2);
    chk("up_led40", led, 5'b00000);
    chk("up_rdy40", req_ready, 1);
    chk("up_mov40", moving, 0);
    step(1);
    chk("up_arr41", arrive, 0);

    // 2 -> 0 with an ignored mid-travel request
    request(2'd0);
    chk("dn_led0", led, 5'b10000);
    chk("dn_dir", dir_up, 0);
    chk("dn_mov", moving, 1);
    req_valid = 1'b1;
    req_floor = 2'd3;
    step(1);
    req_valid = 1'b0;
    step(1);
    chk("dn_ign_led", led, 5'b10000);
    chk("dn_ign_rdy", req_ready, 0);
    step(2);
    chk("dn_led4", led, 5'b01000);
    step(35);
    chk("dn_arr39", arrive, 0);
    step(1);
    chk("dn_arr40", arrive, 1);
    chk("dn_fl40", cur_floor, 0);
    chk("dn_led40", led, 5'b00000);
    step(1);

    // 0 -> 2 with a 10-cycle pause starting at +7
    request(2'd2);
    step(7);
    chk("ps_led7", led, 5'b00010);
    start_stop = 1'b0;
    step(10);
    chk("ps_led17", led, 5'b00010);
    chk("ps_mov17", moving, 1);
    start_stop = 1'b1;
    step(1);
    chk("ps_led18", led, 5'b00100);
    step(31);
    chk("ps_arr49", arrive, 0);
    step(1);
    chk("ps_arr50", arrive, 1);
    chk("ps_fl50", cur_floor, 2);

    // 2 -> 1, then same-floor request at 1
    step(1);
    request(2'd1);
    chk("d1_led0", led, 5'b10000);
    step(19);
    chk("d1_arr19", arrive, 0);
    step(1);
    chk("d1_arr20", arrive, 1);
    chk("d1_fl20", cur_floor, 1);
    step(1);
    request(2'd1);
    chk("same_arr", arrive, 1);
    chk("same_mov", moving, 0);
    chk("same_led", led, 5'b00000);
    chk("same_fl", cur_floor, 1);
    step(1);
    chk("same_arr2", arrive, 0);

    // reset mid-travel on 0 -> 3
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    chk("rs_fl0", cur_floor, 0);
    request(2'd3);
    step(25);
    chk("rs_fl25", cur_floor, 1);
    chk("rs_led25", led, 5'b00010);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    chk("rs_led", led, 5'b00000);
    chk("rs_fl", cur_floor, 0);
    chk("rs_mov", moving, 0);
    chk("rs_arr", arrive, 0);
    chk("rs_rdy", req_ready, 1);
    step(1);
    chk("rs_arr2", arrive, 0);
    chk("rs_mov2", moving, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
